axi4_lite_regbank: RTL and testbench
====================================

Name: axi4_lite_regbank

Overview:
Parametrised AXI4-Lite register-bank slave, the successor to the fixed 32x32 slave.
- Configurable register count and data width.
- Byte-addressed, word-aligned decode; honours WSTRB.
- Independent read and write engines, so a read and a write can be in flight together.
- AW and W are accepted in either order; out-of-range accesses return SLVERR.
- Sits behind the AXI4-Lite master / interconnect as the peripheral control-register block.

Parameters:
- ADDRESS, 32, address bus width in bits.
- DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- NUM_REGS, 32, number of DATA_WIDTH-bit registers; power of two, >= 2.
- ID_VALUE, 32'hA11E_0001, constant returned by register 0 when AXIL_RO_ID_EN is defined.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AWADDR  in  ADDRESS  write address.
- S_AWVALID  in  1  write address valid.
- S_AWREADY  out  1  write address ready.
- S_WDATA  in  DATA_WIDTH  write data.
- S_WSTRB  in  DATA_WIDTH/8  byte write strobes.
- S_WVALID  in  1  write data valid.
- S_WREADY  out  1  write data ready.
- S_BRESP  out  2  write response.
- S_BVALID  out  1  write response valid.
- S_BREADY  in  1  write response ready.
- S_ARADDR  in  ADDRESS  read address.
- S_ARVALID  in  1  read address valid.
- S_ARREADY  out  1  read address ready.
- S_RDATA  out  DATA_WIDTH  read data.
- S_RRESP  out  2  read response.
- S_RVALID  out  1  read data valid.
- S_RREADY  in  1  read data ready.

Behaviour:
- Reset: ARESETN low asynchronously clears all registers and all outputs to 0, and both FSMs go to IDLE.
  - Reset mid-transaction aborts it; no write commits and no response is issued.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); index = addr[LSB +: log2(NUM_REGS)].
  - Access is in-range iff addr >> LSB < NUM_REGS; low LSB bits are ignored.
  - In-range access returns OKAY (2'b00); out-of-range returns SLVERR (2'b10).
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE: S_AWREADY = !aw_held and S_WREADY = !w_held.
  - Each handshake latches its payload into a holding register and sets its held flag.
  - AW and W may arrive in the same cycle or in either order, any number of cycles apart.
  - Commit happens on the cycle both are held, or both complete that same cycle:
    - In-range: byte i of the target register updates iff WSTRB[i]. WSTRB = 0 is a legal no-op returning OKAY.
    - Out-of-range: no register changes; BRESP = SLVERR.
  - On commit, both held flags clear and the FSM moves to W_RESP.
  - S_BVALID rises on the cycle after the later of the AW/W handshakes.
  - W_RESP: AWREADY = WREADY = 0; BVALID and BRESP hold stable until BREADY, then return to W_IDLE.
  - Throughput: at most one write per 2 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - In R_IDLE: S_ARREADY = 1.
  - On AR handshake: S_RDATA and S_RRESP are registered (SLVERR with RDATA = 0 when out-of-range), then move to R_DATA.
  - R_DATA: S_RVALID = 1; RDATA and RRESP hold stable until RREADY, then return to R_IDLE.
  - Latency: RVALID one cycle after the AR handshake.
- Read/write collision: an AR handshake in the same cycle as a write commit to the same register returns the old value. Writes are visible to ARs accepted on later cycles.
- VALID-before-READY dependence: none; the slave never waits for VALID before asserting READY.
- Unused signals: S_BRESP and S_RRESP are 0 whenever their VALID is low.

Optional Feature:
AXIL_RO_ID_EN
- Defined:
  - Register 0 is read-only and always reads ID_VALUE (zero-extended or truncated to DATA_WIDTH).
  - Writes to register 0 change nothing and return SLVERR; all other decode is unchanged.
- Undefined: register 0 is an ordinary read/write register that resets to 0.

Test Plan:
- AW and W in the same cycle: addr 0x08, data 0xDEADBEEF, strb 4'hF -> BVALID next cycle with OKAY. Then read 0x08 -> RVALID one cycle after AR handshake, RDATA 0xDEADBEEF, OKAY.
- W first: data 0x11223344, strb 4'b0101 to addr 0x0C (holding 0xFFFFFFFF). AW follows 3 cycles later -> no commit before AW. Readback is 0xFF22FF44.
- Out-of-range: write to 0x80 (NUM_REGS = 32) -> BRESP 2'b10 and no register changes. Read 0x80 -> RRESP 2'b10, RDATA 0.
- Backpressure: hold BREADY and RREADY low for 5 cycles -> BVALID/BRESP and RVALID/RDATA stay stable, and AWREADY/WREADY and ARREADY stay 0. Release -> both FSMs return to IDLE next cycle.
- Collision: reg 0x04 = 0x1. AR 0x04 in the same cycle as a commit of 0x2 to 0x04 -> RDATA 0x1. A subsequent read returns 0x2.
- Reset mid-write: AW accepted, W not yet sent, ARESETN pulsed low -> all outputs 0 and the register is unchanged (0). With AXIL_RO_ID_EN: read 0x00 -> 0xA11E0001, and a write to 0x00 -> SLVERR.

Source files
------------

// File: rtl/axi4_lite_regbank_if.sv
// AXI4-Lite slave-side bundle for axi4_lite_regbank: AW/W/B write channels and AR/R read channels.
// master modport drives requests and response-readies; slave modport drives readies and responses.
interface axi4_lite_regbank_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );
endinterface

// File: rtl/axi4_lite_regbank.sv
// Parametrised AXI4-Lite register bank: B one cycle after the later AW/W handshake, R one cycle after AR;
// responses hold until BREADY/RREADY with readies low. Define AXIL_RO_ID_EN to make reg 0 a read-only ID.
module axi4_lite_regbank #(
  parameter int          ADDRESS    = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 32,
  parameter logic [31:0] ID_VALUE   = 32'hA11E_0001
) (
  input logic ACLK,
  input logic ARESETN,
  axi4_lite_regbank_if.slave s_axi
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef logic [DATA_WIDTH-1:0] word_t;

  w_state_e             w_state_q, w_state_d;
  logic                 aw_held_q, aw_held_d;
  logic                 w_held_q, w_held_d;
  logic [ADDRESS-1:0]   awaddr_q, awaddr_d;
  word_t                wdata_q, wdata_d;
  logic [STRB_W-1:0]    wstrb_q, wstrb_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  word_t                regs_q [NUM_REGS];
  word_t                regs_d [NUM_REGS];

  r_state_e             r_state_q, r_state_d;
  logic                 rvalid_q, rvalid_d;
  word_t                rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;

  logic                 aw_hs, w_hs, ar_hs;
  logic [ADDRESS-1:0]   cur_addr;
  word_t                cur_data;
  logic [STRB_W-1:0]    cur_strb;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 wr_ok;
  logic                 rd_in_range;
  word_t                rd_val;

  function automatic logic in_range(input logic [ADDRESS-1:0] a);
    return (64'(a) >> LSB) < 64'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDRESS-1:0] a);
    return IDX_W'(a >> LSB);
  endfunction

  // Readies are gated by reset so every output reads 0 while ARESETN is low.
  assign s_axi.S_AWREADY = ARESETN && (w_state_q == W_IDLE) && !aw_held_q;
  assign s_axi.S_WREADY  = ARESETN && (w_state_q == W_IDLE) && !w_held_q;
  assign s_axi.S_ARREADY = ARESETN && (r_state_q == R_IDLE);
  assign s_axi.S_BVALID  = bvalid_q;
  assign s_axi.S_BRESP   = bresp_q;
  assign s_axi.S_RVALID  = rvalid_q;
  assign s_axi.S_RDATA   = rdata_q;
  assign s_axi.S_RRESP   = rresp_q;

  assign aw_hs = s_axi.S_AWVALID && s_axi.S_AWREADY;
  assign w_hs  = s_axi.S_WVALID  && s_axi.S_WREADY;
  assign ar_hs = s_axi.S_ARVALID && s_axi.S_ARREADY;

  // A channel still open this cycle supplies its payload straight from the bus.
  assign cur_addr = aw_held_q ? awaddr_q : s_axi.S_AWADDR;
  assign cur_data = w_held_q  ? wdata_q  : s_axi.S_WDATA;
  assign cur_strb = w_held_q  ? wstrb_q  : s_axi.S_WSTRB;
  assign wr_idx   = reg_idx(cur_addr);
  assign rd_idx   = reg_idx(s_axi.S_ARADDR);
  assign rd_in_range = in_range(s_axi.S_ARADDR);

`ifdef AXIL_RO_ID_EN
  assign wr_ok  = in_range(cur_addr) && (wr_idx != '0);
  assign rd_val = !rd_in_range     ? '0 :
                  (rd_idx == '0)   ? DATA_WIDTH'(ID_VALUE) : regs_q[rd_idx];
`else
  logic unused_id_value;
  assign unused_id_value = ^ID_VALUE;
  assign wr_ok  = in_range(cur_addr);
  assign rd_val = rd_in_range ? regs_q[rd_idx] : '0;
`endif

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.S_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_WDATA;
          wstrb_d  = s_axi.S_WSTRB;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
          if (wr_ok) begin
            bresp_d = RESP_OKAY;
            for (int b = 0; b < STRB_W; b++) begin
              if (cur_strb[b]) regs_d[wr_idx][8*b +: 8] = cur_data[8*b +: 8];
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (s_axi.S_BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q, so an AR coinciding with a commit sees the pre-write value.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_RREADY) begin
          rvalid_d  = 1'b0;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= '{default: '0};
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed and randomized bench for axi4_lite_regbank against an array-based register model.
module tb_axi4_lite_regbank;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 32;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi4_lite_regbank_if #(.ADDRESS(AW), .DATA_WIDTH(DW)) bus();

  axi4_lite_regbank #(
    .ADDRESS(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ID_VALUE(32'hA11E_0001)
  ) dut (
    .ACLK(aclk),
    .ARESETN(aresetn),
    .s_axi(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d,
                                           input logic [3:0] s);
    int unsigned idx = a / 4;
    if (idx >= NR) return 2'b10;
`ifdef AXIL_RO_ID_EN
    if (idx == 0) return 2'b10;
`endif
    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] mdl_read(input logic [31:0] a);
    int unsigned idx = a / 4;
    if (idx >= NR) return {2'b10, 32'h0};
`ifdef AXIL_RO_ID_EN
    if (idx == 0) return {2'b00, 32'hA11E_0001};
`endif
    return {2'b00, mdl[idx]};
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [41:0] all_outs();
    return {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_BRESP, bus.S_ARREADY,
            bus.S_RVALID, bus.S_RRESP, bus.S_RDATA};
  endfunction

  task automatic send_aw(input logic [31:0] a);
    logic hs = 1'b0;
    bus.S_AWADDR = a; bus.S_AWVALID = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin #1; hs = bus.S_AWREADY; tick(); end
    bus.S_AWVALID = 1'b0;
    if (!hs) check("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic hs = 1'b0;
    bus.S_WDATA = d; bus.S_WSTRB = s; bus.S_WVALID = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin #1; hs = bus.S_WREADY; tick(); end
    bus.S_WVALID = 1'b0;
    if (!hs) check("w_timeout", 0, 1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    logic hs = 1'b0;
    bus.S_ARADDR = a; bus.S_ARVALID = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin #1; hs = bus.S_ARREADY; tick(); end
    bus.S_ARVALID = 1'b0;
    if (!hs) check("ar_timeout", 0, 1);
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ha = 1'b0, hw = 1'b0, ra, rw;
    bus.S_AWADDR = a; bus.S_AWVALID = 1'b1;
    bus.S_WDATA = d; bus.S_WSTRB = s; bus.S_WVALID = 1'b1;
    for (int i = 0; i < 20 && !(ha && hw); i++) begin
      #1; ra = bus.S_AWREADY && bus.S_AWVALID; rw = bus.S_WREADY && bus.S_WVALID;
      tick();
      if (ra) begin ha = 1'b1; bus.S_AWVALID = 1'b0; end
      if (rw) begin hw = 1'b1; bus.S_WVALID = 1'b0; end
    end
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
    if (!(ha && hw)) check("aw_w_timeout", 0, 1);
  endtask

  // Called one step after the edge that completed the write address/data pair.
  task automatic finish_b(input logic [1:0] er, input int bdelay, output logic [1:0] obs);
    check("b_latency", bus.S_BVALID, 1);
    check("b_resp", bus.S_BRESP, er);
    obs = bus.S_BRESP;
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check("b_hold", {bus.S_BVALID, bus.S_BRESP, bus.S_AWREADY, bus.S_WREADY}, {1'b1, er, 2'b00});
    end
    bus.S_BREADY = 1'b1;
    tick();
    bus.S_BREADY = 1'b0;
    check("b_release", {bus.S_BVALID, bus.S_BRESP, bus.S_AWREADY, bus.S_WREADY}, 5'b00011);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap, input int bdelay, output logic [1:0] obs);
    logic [1:0] er;
    if (mode == 0) begin
      send_aw_w(a, d, s);
    end else if (mode == 1) begin
      send_w(d, s);
      for (int i = 0; i < gap; i++) begin check("w_first_no_b", bus.S_BVALID, 0); tick(); end
      send_aw(a);
    end else begin
      send_aw(a);
      for (int i = 0; i < gap; i++) begin check("aw_first_no_b", bus.S_BVALID, 0); tick(); end
      send_w(d, s);
    end
    er = mdl_write(a, d, s);
    finish_b(er, bdelay, obs);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay, output logic [33:0] obs);
    logic [33:0] exp;
    send_ar(a);
    exp = mdl_read(a);
    check("r_latency", bus.S_RVALID, 1);
    check("r_resp_data", {bus.S_RRESP, bus.S_RDATA}, exp);
    obs = {bus.S_RRESP, bus.S_RDATA};
    for (int i = 0; i < rdelay; i++) begin
      tick();
      check("r_hold", {bus.S_RVALID, bus.S_ARREADY, bus.S_RRESP, bus.S_RDATA}, {2'b10, exp});
    end
    bus.S_RREADY = 1'b1;
    tick();
    bus.S_RREADY = 1'b0;
    check("r_release", {bus.S_RVALID, bus.S_RRESP, bus.S_ARREADY}, 4'b0001);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  bo;
    logic [33:0] ro;
    logic [1:0]  er;
    logic [33:0] exp_r;
    logic [31:0] ra;

    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
    bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b0;
    mdl_clear();
    #1 aresetn = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 42'h0);
    aresetn = 1'b1;
    tick();
    check("post_reset_ready", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 3'b111);

    // Same-cycle AW+W, then readback.
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, bo);
    do_read(32'h08, 0, ro);
    check("t1_readback", ro, {2'b00, 32'hDEADBEEF});

    // W leads AW by three cycles with sparse strobes.
    do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, bo);
    do_write(32'h0C, 32'h11223344, 4'b0101, 1, 3, 0, bo);
    do_read(32'h0C, 0, ro);
    check("t2_strobe_merge", ro, {2'b00, 32'hFF22FF44});

    // Out-of-range access, then confirm no register moved.
    do_write(32'h80, 32'hCAFEF00D, 4'hF, 0, 0, 0, bo);
    check("t3_wr_slverr", bo, 2'b10);
    do_read(32'h80, 0, ro);
    check("t3_rd_slverr", ro, {2'b10, 32'h0});
    for (int i = 0; i < NR; i++) do_read(32'(i * 4), 0, ro);

    // Both responses back-pressured for five cycles.
    bus.S_AWADDR = 32'h14; bus.S_WDATA = 32'h5A5A_0F0F; bus.S_WSTRB = 4'hF;
    bus.S_ARADDR = 32'h08;
    bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_ARVALID = 1'b1;
    #1 check("t4_ready_in", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 3'b111);
    tick();
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
    exp_r = mdl_read(32'h08);
    er = mdl_write(32'h14, 32'h5A5A_0F0F, 4'hF);
    for (int i = 0; i < 6; i++) begin
      check("t4_b_stable", {bus.S_BVALID, bus.S_BRESP}, {1'b1, er});
      check("t4_r_stable", {bus.S_RVALID, bus.S_RRESP, bus.S_RDATA}, {1'b1, exp_r});
      check("t4_ready_low", {bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY}, 3'b000);
      if (i < 5) tick();
    end
    bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
    tick();
    bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
    check("t4_release", {bus.S_BVALID, bus.S_RVALID, bus.S_AWREADY, bus.S_WREADY, bus.S_ARREADY},
          5'b00111);

    // AR coincides with a commit to the same register.
    do_write(32'h04, 32'h1, 4'hF, 0, 0, 0, bo);
    bus.S_AWADDR = 32'h04; bus.S_WDATA = 32'h2; bus.S_WSTRB = 4'hF; bus.S_ARADDR = 32'h04;
    bus.S_AWVALID = 1'b1; bus.S_WVALID = 1'b1; bus.S_ARVALID = 1'b1;
    tick();
    bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0; bus.S_ARVALID = 1'b0;
    exp_r = mdl_read(32'h04);
    er = mdl_write(32'h04, 32'h2, 4'hF);
    check("t5_old_value", {bus.S_RVALID, bus.S_RRESP, bus.S_RDATA}, {1'b1, exp_r});
    check("t5_old_const", bus.S_RDATA, 32'h1);
    check("t5_b", {bus.S_BVALID, bus.S_BRESP}, {1'b1, er});
    bus.S_BREADY = 1'b1; bus.S_RREADY = 1'b1;
    tick();
    bus.S_BREADY = 1'b0; bus.S_RREADY = 1'b0;
    do_read(32'h04, 0, ro);
    check("t5_new_value", ro, {2'b00, 32'h2});

    // Randomized mix of write orderings, strobes, addresses and response stalls.
    for (int n = 0; n < 160; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 36) * 4 + $urandom_range(0, 3));
      if (op < 3)
        do_write(ra, $urandom, 4'($urandom_range(0, 15)), op, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), bo);
      else
        do_read(ra, int'($urandom_range(0, 2)), ro);
    end

    // Reset lands between AW and W: nothing commits and no response appears.
    do_write(32'h10, 32'h0BAD_0BAD, 4'hF, 0, 0, 0, bo);
    send_aw(32'h10);
    aresetn = 1'b0;
    #1 check("t6_reset_outputs", all_outs(), 42'h0);
    tick();
    mdl_clear();
    aresetn = 1'b1;
    tick();
    check("t6_no_b", bus.S_BVALID, 0);
    do_read(32'h10, 0, ro);
    check("t6_reg_cleared", ro, {2'b00, 32'h0});

`ifdef AXIL_RO_ID_EN
    do_read(32'h00, 0, ro);
    check("id_read", ro, {2'b00, 32'hA11E_0001});
    do_write(32'h00, 32'h1234_5678, 4'hF, 0, 0, 0, bo);
    check("id_write_slverr", bo, 2'b10);
    do_read(32'h00, 0, ro);
    check("id_unchanged", ro, {2'b00, 32'hA11E_0001});
`else
    do_write(32'h00, 32'h1234_5678, 4'hF, 2, 1, 0, bo);
    do_read(32'h00, 0, ro);
    check("reg0_rw", ro, {2'b00, 32'h1234_5678});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
